// File: rtl/serial_bit_feeder.sv
// ============================================================================
// serial_bit_feeder : FIFO-buffered parallel-to-serial feeder, MSB first, gapless
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic                       dout,
  output logic                       dout_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] c_full     = CW'(DEPTH);
  localparam logic [BW-1:0] c_last_bit = BW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_dout;
  logic             r_dout_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic             w_dout_nxt;
  logic             w_dout_valid_nxt;
  logic             w_pop;
  logic             w_push;
  logic             w_ready;
  logic             w_nonempty;
  logic [WIDTH-1:0] w_head;

  assign w_ready    = (r_count != c_full);
  assign w_nonempty = (r_count != '0);
  assign w_push     = data_valid && w_ready;
  assign w_head     = r_mem[r_rptr];

  // Loads use occupancy before this edge's push, so a new word waits one cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_sreg_nxt       = r_sreg;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid;
    w_pop            = 1'b0;

    if (r_state == S_SHIFT && r_bit_cnt != '0) begin
      w_dout_nxt    = r_sreg[WIDTH-1];
      w_sreg_nxt    = r_sreg << 1;
      w_bit_cnt_nxt = r_bit_cnt - 1'b1;
    end else if (w_nonempty) begin
      w_dout_nxt       = w_head[WIDTH-1];
      w_sreg_nxt       = w_head << 1;
      w_bit_cnt_nxt    = c_last_bit;
      w_dout_valid_nxt = 1'b1;
      w_pop            = 1'b1;
      w_state_nxt      = S_SHIFT;
    end else begin
      w_dout_nxt       = 1'b0;
      w_dout_valid_nxt = 1'b0;
      w_state_nxt      = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  assign data_ready = w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_dout_valid || w_nonempty;
  assign fifo_count = r_count;

endmodule

`default_nettype wire
